// File: rtl/param_updown_counter_if.sv
// Button inputs and display-side outputs of the up/down counter.
// W must match the counter's $clog2(MAX_COUNT+1).
interface param_updown_counter_if #(
    parameter int W = 14
);
    logic         btn_mode;
    logic         btn_run;
    logic         btn_clear;
    logic [W-1:0] count;
    logic         dir;
    logic         running;
    logic         tick;
    logic         wrap;

    modport master (
        output btn_mode, btn_run, btn_clear,
        input  count, dir, running, tick, wrap
    );

    modport slave (
        input  btn_mode, btn_run, btn_clear,
        output count, dir, running, tick, wrap
    );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down wrap counter with its own tick divider and three debounced buttons
// (direction toggle, run/stop, clear) feeding a STOP/UP/DOWN state machine.
module pud_btn_filter #(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [1:0]    vld_pipe;
    logic [CW-1:0] cnt_q;
    logic          filt_q;
    logic          filt_d;
    logic          armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            vld_pipe <= '0;
            cnt_q    <= '0;
            filt_q   <= 1'b0;
            filt_d   <= 1'b0;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            vld_pipe <= {vld_pipe[0], 1'b1};
            // A button held through reset stays disarmed until a real release is seen.
            if (vld_pipe[1] && !sync_q[1])
                armed <= 1'b1;
            if (sync_q[1] != filt_q) begin
                if (cnt_q == CLAST) begin
                    filt_q <= sync_q[1];
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
            filt_d <= filt_q;
            press  <= filt_q & ~filt_d & armed;
        end
    end
endmodule

module param_updown_counter #(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int TICK_HZ         = 10,
    parameter int MAX_COUNT       = 9999,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic                   clk,
    input logic                   reset,
    param_updown_counter_if.slave bus
);
    localparam int W       = $clog2(MAX_COUNT + 1);
    localparam int DIV     = CLK_FREQ_HZ / TICK_HZ;
    localparam int DW      = $clog2(DIV);
    localparam int NUM_BTN = 3;
    localparam logic [W-1:0]  CMAX  = W'(MAX_COUNT);
    localparam logic [DW-1:0] DLAST = DW'(DIV - 1);

    typedef enum logic [1:0] {STOP, UP, DOWN} state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;
    logic               p_mode, p_run, p_clear;

    state_t        state;
    logic          dir_q, running_q, tick_q, wrap_q;
    logic [W-1:0]  count_q;
    logic [DW-1:0] div_q;

    assign raw = {bus.btn_clear, bus.btn_run, bus.btn_mode};
    assign {p_clear, p_run, p_mode} = press;

    pud_btn_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTN-1:0] (
        .clk   (clk),
        .reset (reset),
        .raw   (raw),
        .press (press)
    );

    // p_run has priority; a same-cycle p_mode is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STOP;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            case (state)
                STOP: begin
                    if (p_run) begin
                        state     <= dir_q ? DOWN : UP;
                        running_q <= 1'b1;
                    end else if (p_mode) begin
                        dir_q <= ~dir_q;
                    end
                end
                UP: begin
                    if (p_run) begin
                        state     <= STOP;
                        running_q <= 1'b0;
                    end else if (p_mode) begin
                        state <= DOWN;
                        dir_q <= 1'b1;
                    end
                end
                DOWN: begin
                    if (p_run) begin
                        state     <= STOP;
                        running_q <= 1'b0;
                    end else if (p_mode) begin
                        state <= UP;
                        dir_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= STOP;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Tick is suppressed when this cycle stops the counter or restarts the divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (!running_q || p_clear) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= (div_q == DLAST) ? '0 : div_q + 1'b1;
            tick_q <= (div_q == DLAST) && !p_run;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (p_clear) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (tick_q) begin
            if (!dir_q) begin
                count_q <= (count_q == CMAX) ? '0 : count_q + 1'b1;
                wrap_q  <= (count_q == CMAX);
            end else begin
                count_q <= (count_q == '0) ? CMAX : count_q - 1'b1;
                wrap_q  <= (count_q == '0);
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.count   = count_q;
    assign bus.dir     = dir_q;
    assign bus.running = running_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed scenarios plus random button traffic, checked every cycle against a
// timestamp-based reference of presses, tick schedule and count.
module tb_param_updown_counter;
    localparam int CLK_FREQ_HZ = 100;
    localparam int TICK_HZ     = 10;
    localparam int DIV         = 10;
    localparam int MAX_COUNT   = 9;
    localparam int DEB         = 4;
    localparam int W           = 4;
    localparam int PRESS_LAT   = 4 + DEB;  // negedge drive to the edge that consumes the pulse

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_updown_counter_if #(.W(W)) bus ();

    param_updown_counter #(
        .CLK_FREQ_HZ     (CLK_FREQ_HZ),
        .TICK_HZ         (TICK_HZ),
        .MAX_COUNT       (MAX_COUNT),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_count = 0;
    bit m_dir = 0, m_run = 0, m_tick = 0, m_wrap = 0;
    int tick_at = -1;
    int pr_mode = -1, pr_run = -1, pr_clear = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit do_mode, do_run, do_clear, was_run;
        if (reset) begin
            m_count = 0; m_dir = 0; m_run = 0; m_tick = 0; m_wrap = 0;
            tick_at = -1; pr_mode = -1; pr_run = -1; pr_clear = -1;
            return;
        end
        do_mode  = (cyc == pr_mode);
        do_run   = (cyc == pr_run);
        do_clear = (cyc == pr_clear);
        if (do_clear) begin
            m_count = 0;
            m_wrap  = 0;
        end else if (m_tick) begin
            if (!m_dir) begin
                m_wrap  = (m_count == MAX_COUNT);
                m_count = m_wrap ? 0 : m_count + 1;
            end else begin
                m_wrap  = (m_count == 0);
                m_count = m_wrap ? MAX_COUNT : m_count - 1;
            end
        end else begin
            m_wrap = 0;
        end
        was_run = m_run;
        if (do_run) m_run = !m_run;
        else if (do_mode) m_dir = !m_dir;
        if (m_run && (!was_run || do_clear)) tick_at = cyc + DIV;
        m_tick = m_run && (cyc == tick_at);
        if (m_tick) tick_at += DIV;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check("count", bus.count, m_count);
        check("dir", bus.dir, m_dir);
        check("running", bus.running, m_run);
        check("tick", bus.tick, m_tick);
        check("wrap", bus.wrap, m_wrap);
    endtask

    task automatic press(input bit m, input bit r, input bit c, input int hold);
        if (m) begin bus.btn_mode  = 1'b1; pr_mode  = cyc + PRESS_LAT; end
        if (r) begin bus.btn_run   = 1'b1; pr_run   = cyc + PRESS_LAT; end
        if (c) begin bus.btn_clear = 1'b1; pr_clear = cyc + PRESS_LAT; end
        repeat (hold) cycle();
        bus.btn_mode = 1'b0; bus.btn_run = 1'b0; bus.btn_clear = 1'b0;
        repeat (DEB + 6) cycle();
    endtask

    task automatic wait_count(input int val, input int budget);
        int n = 0;
        while (m_count != val && n < budget) begin
            cycle();
            n++;
        end
        check("wait_count", bus.count, val);
    endtask

    initial begin
        int held, mask, hold, idle;
        bus.btn_mode = 1'b0; bus.btn_run = 1'b0; bus.btn_clear = 1'b0;
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        check("rst_count", bus.count, 0);
        check("rst_running", bus.running, 0);
        check("rst_tick", bus.tick, 0);
        repeat (5) cycle();

        // Clean run press: running rises 8 clocks after the raw edge, then wrap 9->0.
        bus.btn_run = 1'b1; pr_run = cyc + PRESS_LAT;
        repeat (7) cycle();
        check("run_lat_early", bus.running, 0);
        cycle();
        check("run_lat", bus.running, 1);
        repeat (2) cycle();
        bus.btn_run = 1'b0;
        wait_count(9, 150);
        wait_count(0, 20);
        check("wrap_pulse", bus.wrap, 1);
        cycle();
        check("wrap_single", bus.wrap, 0);

        // Stop, clear, then a bouncing run button must not start the counter.
        press(0, 1, 0, 8);
        press(0, 0, 1, 8);
        for (int i = 0; i < 5; i++) begin
            bus.btn_run = 1'b1; repeat (3) cycle();
            bus.btn_run = 1'b0; cycle();
        end
        repeat (DEB + 10) cycle();
        check("bounce_running", bus.running, 0);

        // Mode while stopped, then start down from 0: first tick wraps to MAX.
        press(1, 0, 0, 8);
        check("stop_mode_dir", bus.dir, 1);
        check("stop_mode_run", bus.running, 0);
        press(0, 1, 0, 8);
        wait_count(9, 40);
        check("down_wrap", bus.wrap, 1);

        // Flip to UP, then back to DOWN at 3 and follow 2,1,0,9.
        press(1, 0, 0, 8);
        wait_count(3, 80);
        press(1, 0, 0, 8);
        wait_count(0, 60);
        wait_count(9, 20);
        check("down_wrap2", bus.wrap, 1);
        press(0, 1, 0, 8);
        held = m_count;
        repeat (50) cycle();
        check("stopped_hold", bus.count, held);

        // UP run; clear lands on the tick that would leave 5.
        press(1, 0, 0, 8);
        press(0, 1, 0, 8);
        wait_count(5, 150);
        repeat (DIV - PRESS_LAT) cycle();
        bus.btn_clear = 1'b1; pr_clear = cyc + PRESS_LAT;
        repeat (PRESS_LAT) cycle();
        check("clr_tick_count", bus.count, 0);
        check("clr_tick_wrap", bus.wrap, 0);
        bus.btn_clear = 1'b0;
        repeat (DIV) cycle();
        check("clr_restart_early", bus.count, 0);
        cycle();
        check("clr_restart", bus.count, 1);

        // Reset while running and mid-debounce of a held mode button.
        wait_count(7, 150);
        bus.btn_mode = 1'b1;
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_dir", bus.dir, 0);
        check("mid_rst_running", bus.running, 0);
        check("mid_rst_wrap", bus.wrap, 0);
        repeat (20) cycle();
        check("held_no_pulse", bus.dir, 0);
        bus.btn_mode = 1'b0;
        repeat (DEB + 6) cycle();
        press(1, 0, 0, 8);
        check("repress_dir", bus.dir, 1);

        // Random traffic, including simultaneous presses.
        for (int i = 0; i < 40; i++) begin
            mask = $urandom_range(1, 7);
            hold = $urandom_range(DEB + 3, DEB + 12);
            idle = $urandom_range(0, 25);
            repeat (idle) cycle();
            press(mask[0], mask[1], mask[2], hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
